// File: rtl/video_vblank_write_scheduler.sv
// Frame-synchronous write scheduler: holds selected video-slot writes in a FIFO during
// active video and releases them back-to-back after frame_end; all other writes pass straight through.
module video_vblank_write_scheduler #(
    parameter int          DEPTH      = 16,
    parameter logic [7:0]  DEFER_MASK = 8'hFE
) (
    input  logic                     clk_sys,
    input  logic                     reset_sys_n,
    input  logic                     video_cs,
    input  logic                     video_wr,
    input  logic [20:0]              video_addr,
    input  logic [31:0]              video_wr_data,
    input  logic                     frame_end,
    input  logic                     defer_en,
    output logic                     vs_cs,
    output logic                     vs_wr,
    output logic [20:0]              vs_addr,
    output logic [31:0]              vs_wr_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        S_IDLE,
        S_DRAIN
    } state_t;

    state_t         r_state;
    logic [52:0]    r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_drain_left;

    logic           w_accept;
    logic           w_deferred;
    logic           w_full;
    logic           w_push;
    logic           w_forced;
    logic           w_direct;
    logic           w_pop;
    logic [52:0]    w_head;

    // A write is deferred only for a selected register slot while deferral is enabled.
    assign w_accept   = video_cs & video_wr;
    assign w_deferred = w_accept & ~video_addr[20] & DEFER_MASK[video_addr[16:14]] & defer_en;
    assign w_full     = (fifo_count == CW'(DEPTH));
    assign w_push     = w_deferred & ~w_full;
    assign w_forced   = w_deferred & w_full;
    assign w_direct   = (w_accept & ~w_deferred) | w_forced;
    // Direct writes own the bus; the drain simply stalls for that cycle.
    assign w_pop      = (r_state == S_DRAIN) & ~w_direct;
    assign w_head     = r_mem[r_rd_ptr];

    // NOTE: the entry storage has no reset; the pointers and count alone define validity,
    // and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {video_addr, video_wr_data};
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register sees the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_sys or negedge reset_sys_n) begin
        if (!reset_sys_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_drain_left <= '0;
            fifo_count   <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b0;
            vs_cs        <= 1'b0;
            vs_wr        <= 1'b0;
            vs_addr      <= '0;
            vs_wr_data   <= '0;
        end else begin
            vs_cs <= 1'b0;
            vs_wr <= 1'b0;
            if (w_direct) begin
                vs_cs      <= 1'b1;
                vs_wr      <= 1'b1;
                vs_addr    <= video_addr;
                vs_wr_data <= video_wr_data;
            end else if (w_pop) begin
                vs_cs      <= 1'b1;
                vs_wr      <= 1'b1;
                vs_addr    <= w_head[52:32];
                vs_wr_data <= w_head[31:0];
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (w_pop && !w_push) begin
                fifo_count <= fifo_count - CW'(1);
            end

            if (w_forced) begin
                overflow <= 1'b1;
            end

            // The snapshot excludes entries pushed while draining, keeping each frame atomic.
            case (r_state)
                S_IDLE: begin
                    if (frame_end && fifo_count != '0) begin
                        r_state      <= S_DRAIN;
                        r_drain_left <= fifo_count;
                        busy         <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_pop) begin
                        r_drain_left <= r_drain_left - CW'(1);
                        if (r_drain_left == CW'(1)) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/video_vblank_write_scheduler.md
# video_vblank_write_scheduler

Frame-synchronous write scheduler between the FPro video bus and `video_sys_daisy`. Writes that target selected video slots (sprite, OSD, bar, and gray cores) are buffered in a FIFO during active video. They are released back-to-back only after the frame counter's `frame_end`, so sprite position and control changes never tear mid-frame. Frame-buffer writes and non-deferred slot writes pass straight through. The block is the sole master of the video bus seen by `video_sys_daisy`.

## Interface
- `DEPTH`, 16: FIFO entries (power of 2, 4..64).
- `DEFER_MASK`, 8'hFE: bit i=1 defers writes to video slot i; slot 0 (sync) is immediate by default.
- `clk_sys` in 1: system clock. Single clock domain.
- `reset_sys_n` in 1: reset, asynchronous, active-low.
- `video_cs`, `video_wr` in 1 each: FPro-side strobes. A write is accepted when both are 1, one cycle per write.
- `video_addr` in 21: FPro word address. Bit 20=1 is the frame buffer; bit 20=0 with bits [16:14] is the slot number.
- `video_wr_data` in 32: write data.
- `frame_end` in 1: one-cycle pulse from `frame_counter`.
- `defer_en` in 1: 0 makes all new writes pass through.
- `vs_cs`, `vs_wr` out 1 each: strobes to `video_sys_daisy`.
- `vs_addr` out 21, `vs_wr_data` out 32: address and data to `video_sys_daisy`.
- `fifo_count` out log2(DEPTH)+1: current occupancy.
- `overflow` out 1: sticky. Cleared only by reset.
- `busy` out 1: 1 while in DRAIN.

## Operation
- Incoming write classes:
  - Deferred: `video_addr[20]`=0, `DEFER_MASK[video_addr[16:14]]`=1, and `defer_en`=1.
  - Immediate: every other accepted write.
- Immediate write: issued on the vs bus next cycle, with priority over the drain.
- Deferred write with `fifo_count`<DEPTH: {addr, data} is pushed and nothing is issued.
- Deferred write with `fifo_count`==DEPTH: the write is issued immediately as a forced write and `overflow` is set to 1. Order relative to the queued entries is not preserved; this is the documented consequence of overflow.
- State machine: IDLE, DRAIN.
  - IDLE→DRAIN on `frame_end`=1 with `fifo_count`>0. At this transition `drain_left` latches `fifo_count` (the snapshot).
  - In DRAIN, on any cycle with no immediate or forced write, the FIFO head is issued and popped, and `drain_left` decrements.
  - DRAIN→IDLE on the pop that makes `drain_left` 0.
  - `frame_end` during DRAIN is ignored.
- Entries pushed during DRAIN are not part of the snapshot. They wait for the next `frame_end`, so one frame's updates stay atomic.
- Push and pop in the same cycle are legal; `fifo_count` is unchanged.
- Clearing `defer_en` does not flush the FIFO. Queued entries still drain at the next `frame_end`.
- FIFO is in-order, with circular pointers that wrap modulo DEPTH.

## Timing
- Reset (async assert, sync release): all outputs 0. FIFO empty, state IDLE, `drain_left` 0, `overflow` 0.
- vs outputs are registered:
  - An immediate or forced write appears exactly 1 cycle after acceptance and holds for 1 cycle.
  - `vs_cs`=`vs_wr`=1 only on issue cycles; otherwise both are 0.
  - `vs_addr` and `vs_wr_data` hold their last values when idle.
- Drain timing:
  - The first drained entry appears 1 cycle after the DRAIN entry cycle.
  - Uninterrupted, N entries take N consecutive cycles.
  - Each immediate write inserts exactly one stall cycle into the drain.
- `fifo_count` updates the cycle after a push or pop. Full/empty decisions use the registered count.
- `busy` is 1 starting the cycle after `frame_end` and drops in the cycle after the last pop.
- Reset mid-DRAIN: remaining entries are discarded and the block returns to IDLE. No partial write is emitted after reset release.

## Test plan
- Passthrough: write to addr 0x100005 (frame buffer), data 0xABC. Required: `vs_cs`=`vs_wr`=1 next cycle with the same addr and data, and `fifo_count` stays 0.
- Deferral and drain: 3 writes to slot 3 (addr 0x0C000..0x0C002). Required: no vs activity and `fifo_count`=3. Then `frame_end`: 3 consecutive issues in order, `busy` high for 3 cycles, `fifo_count`=0.
- Priority/stall: during a drain of 4 entries, an immediate slot-0 write arrives on the 2nd drain cycle. Required: the immediate write is issued on that cycle's output slot and the drain completes in 5 cycles, in order.
- Snapshot: `frame_end` with 2 entries, then 1 deferred write during DRAIN. Required: only 2 entries are issued, the state returns to IDLE with `fifo_count`=1, and that entry issues at the next `frame_end`.
- Overflow: 17 deferred writes with DEPTH=16. Required: the 17th is issued immediately, `overflow`=1, and `fifo_count`=16. `overflow` stays 1 after the drain and is cleared by `reset_sys_n`=0.
- Mid-drain reset: assert `reset_sys_n` after 2 of 5 pops. Required: outputs go to 0 asynchronously, `fifo_count`=0, and no vs writes occur after release.
